// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between two requesters and the register-file arbiter.
// The master side is the requester/register-file environment; the slave side
// is the arbiter itself.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              rf_stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic              last_grant;
  logic [7:0]        wr_count;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output rf_stall,
    input  req0_ready, req1_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  last_grant, wr_count
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  rf_stall,
    output req0_ready, req1_ready,
    output rf_we, rf_waddr, rf_wdata,
    output last_grant, wr_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for a single register-file write port.
// One write is accepted per cycle and issued to the register file on the
// following cycle through registered rf_we/rf_waddr/rf_wdata.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic {StIdle, StWrite} state_t;

  state_t            state;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              last_grant;
  logic [7:0]        wr_count;

  logic win0;
  logic win1;
  logic ready0;
  logic ready1;
  logic accept;

  // Round-robin winner: a lone valid requester wins; on contention the
  // requester that was not granted last wins. Readies never look at each
  // other, only at valids, stall and reset.
  always_comb begin
    win0   = bus.req0_valid & (~bus.req1_valid | last_grant);
    win1   = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    ready0 = win0 & ~bus.rf_stall & ~rst;
    ready1 = win1 & ~bus.rf_stall & ~rst;
    accept = ready0 | ready1;
  end

  // FSM with registered outputs: WRITE for exactly the cycle after each
  // acceptance. Stall only gates new acceptances, so an issued write is
  // never withdrawn. last_grant resets to 1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      last_grant <= 1'b1;
      wr_count   <= 8'd0;
    end else if (accept) begin
      state      <= StWrite;
      we         <= 1'b1;
      waddr      <= ready0 ? bus.req0_addr : bus.req1_addr;
      wdata      <= ready0 ? bus.req0_data : bus.req1_data;
      last_grant <= ready1;
      wr_count   <= wr_count + 8'd1;
    end else begin
      // Address/data hold their last values while idle.
      state <= StIdle;
      we    <= 1'b0;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rf_we      = we;
  assign bus.rf_waddr   = waddr;
  assign bus.rf_wdata   = wdata;
  assign bus.last_grant = last_grant;
  assign bus.wr_count   = wr_count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: accepted writes predicted by a
// reference arbitration model are queued and compared when issued.
module tb_regfile_write_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  wr_t           sb[$];
  logic          m_last  = 1'b1;
  logic [7:0]    m_count = 8'd0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_data  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check what the previous edge produced, check the
  // readies against the model, predict the coming edge, then cross it.
  task automatic tick();
    wr_t  e;
    logic w0, w1, r0, r1;
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rf_we", 32'(bus.rf_we), 32'd1);
      check("rf_waddr", 32'(bus.rf_waddr), 32'(e.addr));
      check("rf_wdata", 32'(bus.rf_wdata), 32'(e.data));
      m_addr = e.addr;
      m_data = e.data;
    end else begin
      check("rf_we_idle", 32'(bus.rf_we), 32'd0);
      check("rf_waddr_hold", 32'(bus.rf_waddr), 32'(m_addr));
      check("rf_wdata_hold", 32'(bus.rf_wdata), 32'(m_data));
    end
    check("wr_count", 32'(bus.wr_count), 32'(m_count));
    check("last_grant", 32'(bus.last_grant), 32'(m_last));
    w0 = bus.req0_valid && (!bus.req1_valid || m_last);
    w1 = bus.req1_valid && (!bus.req0_valid || !m_last);
    r0 = w0 && !bus.rf_stall && !rst;
    r1 = w1 && !bus.rf_stall && !rst;
    check("req0_ready", 32'(bus.req0_ready), 32'(r0));
    check("req1_ready", 32'(bus.req1_ready), 32'(r1));
    if (r0 || r1) begin
      e.addr = r0 ? bus.req0_addr : bus.req1_addr;
      e.data = r0 ? bus.req0_data : bus.req1_data;
      sb.push_back(e);
      m_last  = r1;
      m_count = m_count + 8'd1;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    check("rst_rf_wdata", 32'(bus.rf_wdata), 32'd0);
    check("rst_last_grant", 32'(bus.last_grant), 32'd1);
    check("rst_wr_count", 32'(bus.wr_count), 32'd0);
    check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    sb.delete();
    m_last  = 1'b1;
    m_count = 8'd0;
    m_addr  = '0;
    m_data  = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_data  = '0;
    bus.rf_stall   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    // Valid held during reset must not be granted.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    do_reset();

    // Single write from requester 0.
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd3;
    bus.req0_data  = 8'hA5;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    tick();
    check("single_count", 32'(bus.wr_count), 32'd1);

    // Both continuously valid: alternate 0,1,0,1.
    do_reset();
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd1;
    bus.req0_data  = 8'h11;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 4'd2;
    bus.req1_data  = 8'h22;
    for (int i = 0; i < 4; i++) tick();
    idle_inputs();
    tick();
    check("b2b_last_grant", 32'(bus.last_grant), 32'd1);
    check("b2b_count", 32'(bus.wr_count), 32'd4);
    tick();

    // Same-address collision serialised 0x10 then 0x20.
    do_reset();
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd5;
    bus.req0_data  = 8'h10;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 4'd5;
    bus.req1_data  = 8'h20;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    check("collision_final", 32'(bus.rf_wdata), 32'h20);
    tick();

    // Stall for three cycles, release, then stall over the in-flight write.
    do_reset();
    idle_inputs();
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 4'd7;
    bus.req1_data  = 8'h77;
    bus.rf_stall   = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.rf_stall = 1'b0;
    tick();
    bus.req1_valid = 1'b0;
    bus.rf_stall   = 1'b1;
    tick();
    bus.rf_stall = 1'b0;
    tick();

    // Valid withdrawn without acceptance changes nothing.
    bus.req0_valid = 1'b1;
    bus.rf_stall   = 1'b1;
    tick();
    idle_inputs();
    tick();

    // 256 writes: counter wraps to zero.
    do_reset();
    idle_inputs();
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.req0_addr = AW'(i);
      bus.req0_data = DW'(i ^ 8'h5A);
      tick();
    end
    idle_inputs();
    tick();
    check("wrap_count", 32'(bus.wr_count), 32'd0);
    check("wrap_last_data", 32'(bus.rf_wdata), 32'(8'd255 ^ 8'h5A));
    tick();

    // Reset while a write is in flight; first grant afterwards goes to 0.
    do_reset();
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 4'd9;
    bus.req0_data  = 8'h99;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 4'd10;
    bus.req1_data  = 8'hAA;
    tick();
    check("inflight_we", 32'(bus.rf_we), 32'd1);
    do_reset();
    tick();
    bus.req0_valid = 1'b0;
    tick();
    idle_inputs();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
